// File: rtl/xor_parity_sched_pkg.sv
// rtl/xor_parity_sched_pkg.sv - state codes shared by the parity scheduler files
package xor_parity_sched_pkg;

    // Two-bit state encoding; code 3 is unused and recovers to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic win_valid,
    output logic win_idx
);

    // A lone request wins outright; on a tie the requester not served last wins
    always_comb begin
        win_valid = req0 | req1;
        if (req0 && req1) begin
            win_idx = ~last_gnt;
        end else begin
            win_idx = req1;
        end
    end

endmodule

// File: rtl/xorGate_st.sv
// rtl/xorGate_st.sv - structural 2-input XOR cell, the single shared XOR resource
module xorGate_st (
    input  logic a,
    input  logic b,
    output logic y
);

    xor u_xor (y, a, b);

endmodule

// File: rtl/xor_parity_sched.sv
// rtl/xor_parity_sched.sv - serial parity engine sharing one XOR cell between two requesters
module xor_parity_sched
    import xor_parity_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             parity,
    output logic             owner
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             acc_next;
    logic             last_gnt;
    logic             win_valid;
    logic             win_idx;
    logic             last_bit;

    rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    // Every accumulated bit passes through this one cell
    xorGate_st u_xor (
        .a (acc),
        .b (sr[0]),
        .y (acc_next)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register; reset abandons any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: arbitrate in IDLE, shift WIDTH bits in RUN, one-cycle DONE
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = win_valid ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_RUN) || (state == S_DONE);
        done = (state == S_DONE);
    end

    // Datapath: latch the winner's word, then fold one bit per cycle into acc
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            cnt      <= '0;
            acc      <= 1'b0;
            parity   <= 1'b0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (state == S_IDLE && win_valid) begin
                sr       <= win_idx ? data1 : data0;
                acc      <= 1'b0;
                cnt      <= '0;
                owner    <= win_idx;
                last_gnt <= win_idx;
                gnt0     <= ~win_idx;
                gnt1     <= win_idx;
            end else if (state == S_RUN) begin
                acc <= acc_next;
                sr  <= sr >> 1;
                cnt <= cnt + 1'b1;
                if (last_bit) begin
                    parity <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_parity_sched.sv
// tb/tb_xor_parity_sched.sv - scoreboard bench for xor_parity_sched
module tb_xor_parity_sched;

    localparam int WIDTH = 8;

    typedef struct {
        bit own;
        bit par;
        int cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               par;
    } pend_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             parity;
    logic             owner;

    exp_t  sb[$];
    pend_t pend0[$];
    pend_t pend1[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    busy_run = 0;
    bit    prev_done = 1'b0;

    xor_parity_sched #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .data0  (data0),
        .req1   (req1),
        .data1  (data1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .busy   (busy),
        .done   (done),
        .parity (parity),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant handler: retire a pending request and push its expected result
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (gnt0 || gnt1) check("gnt_exclusive", int'(gnt0 & gnt1), 0);
            if (gnt0) begin
                check("gnt0_expected", int'(pend0.size() != 0), 1);
                if (pend0.size() != 0) begin
                    p = pend0.pop_front();
                    sb.push_back('{1'b0, p.par, cyc + WIDTH});
                    if (pend0.size() == 0) req0 = 1'b0;
                    else data0 = pend0[0].d;
                end
            end
            if (gnt1) begin
                check("gnt1_expected", int'(pend1.size() != 0), 1);
                if (pend1.size() != 0) begin
                    p = pend1.pop_front();
                    sb.push_back('{1'b1, p.par, cyc + WIDTH});
                    if (pend1.size() == 0) req1 = 1'b0;
                    else data1 = pend1[0].d;
                end
            end
        end
    end

    // Monitor: compare each done against the scoreboard, track busy length
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_single_cycle", int'(prev_done), 0);
                check("done_has_busy", int'(busy), 1);
                check("done_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("parity", int'(parity), int'(e.par));
                    check("owner", int'(owner), int'(e.own));
                    check("done_latency", cyc, e.cyc);
                end
            end
            prev_done = done;
            if (rst) begin
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                check("busy_length", busy_run, WIDTH + 1);
                busy_run = 0;
            end
        end
    end

    task automatic queue0(input logic [WIDTH-1:0] d, input bit par);
        pend0.push_back('{d, par});
        data0 = pend0[0].d;
        req0  = 1'b1;
    endtask

    task automatic queue1(input logic [WIDTH-1:0] d, input bit par);
        pend1.push_back('{d, par});
        data1 = pend1[0].d;
        req1  = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n >= 300), 0);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_gnt0"}, int'(gnt0), 0);
        check({name, "_gnt1"}, int'(gnt1), 0);
        check({name, "_parity"}, int'(parity), 0);
        check({name, "_owner"}, int'(owner), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Tie right after reset: req0 first, then req1 in the next IDLE
        queue0(8'h03, 1'b0);
        queue1(8'h07, 1'b1);
        wait_idle();

        // Single request, grant visible one cycle after raising req
        queue0(8'hB5, 1'b1);
        @(negedge clk);
        check("gnt0_pulse", int'(gnt0), 1);
        wait_idle();

        // First/last bit and counter boundary vectors
        queue0(8'h00, 1'b0); wait_idle();
        queue0(8'hFF, 1'b0); wait_idle();
        queue0(8'h80, 1'b1); wait_idle();
        queue0(8'h01, 1'b1); wait_idle();

        // One-cycle req1 pulse mid-RUN is lost
        queue0(8'h3C, 1'b0);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        check("pulse_busy", int'(busy), 1);
        check("pulse_owner", int'(owner), 0);
        wait_idle();

        // req1 held alone for two words
        queue1(8'h0F, 1'b0);
        queue1(8'h10, 1'b1);
        wait_idle();

        // Reset mid-RUN aborts the word
        queue0(8'hB5, 1'b1);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        check_zero("midrun_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("after_reset_idle", int'(busy), 0);

        // Engine works again after the abort
        queue0(8'hA1, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
